// File: rtl/riscv_gpr_wb_ctrl_if.sv
// Write-back bus between the execution units and the GPR write-back controller.
// It carries the requester handshake (valid/ready/addr/data) and the register-file write port.
interface riscv_gpr_wb_ctrl_if #(
  parameter int XLEN = 32,
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ*5-1:0]    req_addr_i;
  logic [NREQ*XLEN-1:0] req_data_i;
  logic                 gpr_we_o;
  logic [4:0]           gpr_wa_o;
  logic [XLEN-1:0]      gpr_wd_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i,
    output req_ready_o, gpr_we_o, gpr_wa_o, gpr_wd_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i,
    input  req_ready_o, gpr_we_o, gpr_wa_o, gpr_wd_o
  );
endinterface

// File: rtl/riscv_gpr_wb_ctrl.sv
// GPR write-back arbiter with a registered write port and a pending-write scoreboard.
// Defining RISCV_GPR_WB_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed top priority.
module riscv_gpr_wb_ctrl #(
  parameter int XLEN = 32,
  parameter int NREQ = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  riscv_gpr_wb_ctrl_if.slave        wb,
  input  logic                      sb_set_i,
  input  logic [4:0]                sb_set_addr_i,
  output logic                      sb_set_ready_o,
  input  logic [4:0]                sb_ra1_i,
  input  logic [4:0]                sb_ra2_i,
  output logic                      sb_busy1_o,
  output logic                      sb_busy2_o,
  output logic                      sb_err_o
);

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gidx;
  logic            gvld;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;
  logic            we_d;

  logic            we_q;
  logic [4:0]      wa_q;
  logic [XLEN-1:0] wd_q;
  logic            err_q;

`ifdef RISCV_GPR_WB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;
`endif

  // Search starts at the rotation pointer (RR) or at requester 0 (fixed)
  always_comb begin
    int idx;
    gnt  = '0;
    gidx = '0;
    gvld = 1'b0;
    idx  = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef RISCV_GPR_WB_RR_EN
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
`else
      idx = k;
`endif
      if (!gvld && wb.req_valid_i[idx]) begin
        gnt[idx] = 1'b1;
        gidx     = PW'(idx);
        gvld     = 1'b1;
      end
    end
    if (!rst_ni) begin
      gnt  = '0;
      gvld = 1'b0;
    end
  end

  assign sel_addr = wb.req_addr_i[5*int'(gidx) +: 5];
  assign sel_data = wb.req_data_i[XLEN*int'(gidx) +: XLEN];
  // x0 writes are consumed but never reach the register file
  assign we_d     = gvld && (sel_addr != 5'd0);

`ifdef RISCV_GPR_WB_RR_EN
  assign ptr_d = (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)   ptr_q <= '0;
    else if (gvld) ptr_q <= ptr_d;
  end
`endif

  // Scoreboard: x0 is a hard-wired zero entry
  logic [31:1][1:0] cnt_q;
  logic [31:0][1:0] cnt_all;
  logic             set_fire;
  logic             commit_err;

  assign cnt_all        = {cnt_q, 2'b00};
  assign sb_set_ready_o = (cnt_all[sb_set_addr_i] != 2'd3);
  assign set_fire       = sb_set_i && sb_set_ready_o && (sb_set_addr_i != 5'd0);
  assign commit_err     = we_q && (cnt_all[wa_q] == 2'd0) &&
                          !(set_fire && (sb_set_addr_i == wa_q));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      we_q <= we_d;
      if (we_d) begin
        wa_q <= sel_addr;
        wd_q <= sel_data;
      end
      if (commit_err) err_q <= 1'b1;
      for (int r = 1; r < 32; r++) begin
        if (set_fire && (sb_set_addr_i == 5'(r)) && !(we_q && (wa_q == 5'(r))))
          cnt_q[r] <= cnt_q[r] + 2'd1;
        else if (we_q && (wa_q == 5'(r)) && !(set_fire && (sb_set_addr_i == 5'(r))) &&
                 (cnt_q[r] != 2'd0))
          cnt_q[r] <= cnt_q[r] - 2'd1;
      end
    end
  end

  assign wb.req_ready_o = gnt;
  assign wb.gpr_we_o    = we_q;
  assign wb.gpr_wa_o    = wa_q;
  assign wb.gpr_wd_o    = wd_q;
  assign sb_busy1_o     = (cnt_all[sb_ra1_i] != 2'd0);
  assign sb_busy2_o     = (cnt_all[sb_ra2_i] != 2'd0);
  assign sb_err_o       = err_q;

endmodule

// File: tb/tb_riscv_gpr_wb_ctrl.sv
// Randomized and directed checks of riscv_gpr_wb_ctrl against a queue-free counting model.
module tb_riscv_gpr_wb_ctrl;
  localparam int XLEN = 32;
  localparam int NREQ = 3;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic sb_set_i;
  logic [4:0] sb_set_addr_i, sb_ra1_i, sb_ra2_i;
  logic sb_set_ready_o, sb_busy1_o, sb_busy2_o, sb_err_o;

  riscv_gpr_wb_ctrl_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

  riscv_gpr_wb_ctrl #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wb(bus.slave),
    .sb_set_i(sb_set_i), .sb_set_addr_i(sb_set_addr_i), .sb_set_ready_o(sb_set_ready_o),
    .sb_ra1_i(sb_ra1_i), .sb_ra2_i(sb_ra2_i),
    .sb_busy1_o(sb_busy1_o), .sb_busy2_o(sb_busy2_o), .sb_err_o(sb_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int              m_cnt [32];
  int              m_ptr;
  logic            m_we, m_err;
  logic [4:0]      m_wa;
  logic [XLEN-1:0] m_wd;

  logic [NREQ-1:0] last_rdy;
  logic            last_sr, last_b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_ptr = 0; m_we = 0; m_err = 0; m_wa = '0; m_wd = '0;
  endtask

  task automatic chk_regs();
    chk("gpr_we", 64'(bus.gpr_we_o), 64'(m_we));
    chk("gpr_wa", 64'(bus.gpr_wa_o), 64'(m_wa));
    chk("gpr_wd", 64'(bus.gpr_wd_o), 64'(m_wd));
    chk("sb_err", 64'(sb_err_o), 64'(m_err));
  endtask

  // One cycle: called at a negedge, returns at the following negedge
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*5-1:0] a,
                      input logic [NREQ*XLEN-1:0] d, input logic s, input logic [4:0] sa,
                      input logic [4:0] r1, input logic [4:0] r2);
    int g, inc, dec, nc;
    logic [4:0] ga;
    logic sr;
    chk_regs();
    bus.req_valid_i = v; bus.req_addr_i = a; bus.req_data_i = d;
    sb_set_i = s; sb_set_addr_i = sa; sb_ra1_i = r1; sb_ra2_i = r2;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
`ifdef RISCV_GPR_WB_RR_EN
      int i = (m_ptr + k) % NREQ;
`else
      int i = k;
`endif
      if (g < 0 && v[i]) g = i;
    end
    sr = (m_cnt[sa] != 3);
    chk("req_ready", 64'(bus.req_ready_o), (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("set_ready", 64'(sb_set_ready_o), 64'(sr));
    chk("busy1", 64'(sb_busy1_o), 64'(m_cnt[r1] != 0));
    chk("busy2", 64'(sb_busy2_o), 64'(m_cnt[r2] != 0));
    last_rdy = bus.req_ready_o; last_sr = sb_set_ready_o; last_b1 = sb_busy1_o;
    inc = (s && sr && sa != 0) ? int'(sa) : 0;
    dec = m_we ? int'(m_wa) : 0;
    for (int r = 1; r < 32; r++) begin
      nc = m_cnt[r] + (r == inc ? 1 : 0) - (r == dec ? 1 : 0);
      if (nc < 0) begin m_err = 1; nc = 0; end
      m_cnt[r] = nc;
    end
    m_we = 0;
    if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
      ga = a[5*g +: 5];
      if (ga != 0) begin m_we = 1; m_wa = ga; m_wd = d[XLEN*g +: XLEN]; end
    end
    @(posedge clk_i); @(negedge clk_i);
  endtask

  task automatic idle(input logic [4:0] r1);
    step('0, '0, '0, 1'b0, 5'd0, r1, 5'd0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    bus.req_valid_i = '1; bus.req_addr_i = {5'd3, 5'd2, 5'd1}; bus.req_data_i = '1;
    sb_set_i = 1'b0; sb_set_addr_i = '0; sb_ra1_i = '0; sb_ra2_i = '0;
    #1;
    chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
    @(posedge clk_i); @(negedge clk_i);
    chk("rst_ready2", 64'(bus.req_ready_o), 64'd0);
    chk("rst_we", 64'(bus.gpr_we_o), 64'd0);
    chk("rst_wa", 64'(bus.gpr_wa_o), 64'd0);
    chk("rst_wd", 64'(bus.gpr_wd_o), 64'd0);
    chk("rst_err", 64'(sb_err_o), 64'd0);
    for (int r = 0; r < 32; r++) begin
      sb_ra1_i = 5'(r); #1;
      chk("rst_busy", 64'(sb_busy1_o), 64'd0);
    end
    model_reset();
    rst_ni = 1'b1;
    bus.req_valid_i = '0;
  endtask

  initial begin
    int exp_g;
    rst_ni = 1'b0;
    bus.req_valid_i = '0; bus.req_addr_i = '0; bus.req_data_i = '0;
    sb_set_i = 1'b0; sb_set_addr_i = '0; sb_ra1_i = '0; sb_ra2_i = '0;
    @(negedge clk_i);
    do_reset();

    // contention, all targeting x0 so the scoreboard stays clean
    for (int k = 0; k < 6; k++) begin
      step(3'b111, '0, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd0, 5'd0, 5'd0);
`ifdef RISCV_GPR_WB_RR_EN
      exp_g = k % 3;
`else
      exp_g = 0;
`endif
      chk("contention", 64'(last_rdy), 64'd1 << exp_g);
    end

    // single write to x5 after marking it pending
    step('0, '0, '0, 1'b1, 5'd5, 5'd5, 5'd0);
    step(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 1'b0, 5'd0, 5'd5, 5'd0);
    chk("sw_ready", 64'(last_rdy), 64'b010);
    chk("sw_we", 64'(bus.gpr_we_o), 64'd1);
    chk("sw_wa", 64'(bus.gpr_wa_o), 64'd5);
    chk("sw_wd", 64'(bus.gpr_wd_o), 64'hDEADBEEF);
    idle(5'd5);
    chk("sw_we_off", 64'(bus.gpr_we_o), 64'd0);
    chk("sw_no_err", 64'(sb_err_o), 64'd0);

    // scoreboard on x7
    step('0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
    step('0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
    idle(5'd7);
    chk("x7_busy2", 64'(last_b1), 64'd1);
    step(3'b001, {5'd0, 5'd0, 5'd7}, 96'h55, 1'b0, 5'd0, 5'd7, 5'd0);
    idle(5'd7);
    idle(5'd7);
    chk("x7_busy1", 64'(last_b1), 64'd1);
    step(3'b001, {5'd0, 5'd0, 5'd7}, 96'h66, 1'b0, 5'd0, 5'd7, 5'd0);
    idle(5'd7);
    chk("x7_commit_busy", 64'(last_b1), 64'd1);
    idle(5'd7);
    chk("x7_free", 64'(last_b1), 64'd0);
    for (int k = 0; k < 3; k++) step('0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
    step('0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
    chk("x7_full", 64'(last_sr), 64'd0);

    // x9: set and commit on the same edge
    step('0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
    step(3'b010, {5'd0, 5'd9, 5'd0}, 96'h77 << 32, 1'b0, 5'd0, 5'd9, 5'd0);
    step('0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
    idle(5'd9);
    chk("x9_busy", 64'(last_b1), 64'd1);
    chk("x9_no_err", 64'(sb_err_o), 64'd0);

    // write to x0
    step(3'b100, '0, 96'h1 << 64, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("x0_ready", 64'(last_rdy), 64'b100);
    chk("x0_we", 64'(bus.gpr_we_o), 64'd0);

    // commit to x3 with nothing pending
    step(3'b001, {5'd0, 5'd0, 5'd3}, 96'h33, 1'b0, 5'd0, 5'd3, 5'd0);
    idle(5'd3);
    chk("x3_err", 64'(sb_err_o), 64'd1);
    for (int k = 0; k < 3; k++) idle(5'd3);
    chk("x3_err_sticky", 64'(sb_err_o), 64'd1);

    // randomized traffic over a small register window
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [NREQ*5-1:0] a;
      logic [NREQ*XLEN-1:0] d;
      for (int i = 0; i < NREQ; i++) begin
        a[5*i +: 5] = 5'($urandom_range(0, 7));
        d[XLEN*i +: XLEN] = $urandom;
      end
      step(NREQ'($urandom), a, d, 1'($urandom), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // reset while a write is staged
    step(3'b001, {5'd0, 5'd0, 5'd5}, 96'hAB, 1'b1, 5'd5, 5'd0, 5'd0);
    chk("mid_staged", 64'(bus.gpr_we_o), 64'(m_we));
    do_reset();

    for (int n = 0; n < 100; n++)
      step(NREQ'($urandom), NREQ*5'($urandom), {$urandom, $urandom, $urandom}, 1'($urandom),
           5'($urandom), 5'($urandom), 5'($urandom));
    chk_regs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/riscv_gpr_wb_ctrl.md
# riscv_gpr_wb_ctrl

Write-back controller for the core's 32-entry general-purpose register file. It shares the register file's single write port between `NREQ` write-back sources (ALU, LSU, MDU, …) with a registered output stage. It also keeps a per-register pending-write scoreboard that the issue stage queries for RAW/WAW hazard stalls. It sits between the execution units and the register file and is the only driver of the file's `we`/`wa`/`wd` inputs.

## Interface
Parameters:
- `XLEN`, 32, data width of register values.
- `NREQ`, 3, number of write-back requesters; legal range 2..8.

Ports:
- `clk_i` input 1: core clock; all state changes on its rising edge.
- `rst_ni` input 1: reset; synchronous, active-low.
- `req_valid_i` input `NREQ`: requester i has a write-back pending.
- `req_ready_o` output `NREQ`: requester i is granted this cycle; transfer when valid && ready.
- `req_addr_i` input `NREQ*5`: destination register; field i is `[5*i +: 5]`.
- `req_data_i` input `NREQ*XLEN`: write data; field i is `[XLEN*i +: XLEN]`.
- `gpr_we_o` output 1: register-file write enable.
- `gpr_wa_o` output 5: register-file write address.
- `gpr_wd_o` output `XLEN`: register-file write data.
- `sb_set_i` input 1: issue stage dispatches an instruction with destination `sb_set_addr_i`.
- `sb_set_addr_i` input 5: destination being marked pending.
- `sb_set_ready_o` output 1: a set is allowed this cycle.
- `sb_ra1_i`, `sb_ra2_i` input 5 each: source registers being checked.
- `sb_busy1_o`, `sb_busy2_o` output 1 each: the corresponding source has a pending write.
- `sb_err_o` output 1: sticky flag for a commit to a register with no pending count.

## Operation
**Arbitration**
- Each cycle, at most one valid requester is granted: `req_ready_o` is one-hot or zero.
- Ready depends combinationally on valid. No requester may make valid depend on ready.
- The output stage never back-pressures, so at most one write is accepted per cycle.
- Priority order depends on the Configuration macro.

**Output stage**
- On a grant to requester i with `req_addr_i[i] != 0`, the next cycle drives `gpr_we_o=1`, `gpr_wa_o=addr`, `gpr_wd_o=data`.
- If there is no grant, or the granted address is x0, `gpr_we_o=0` next cycle.
- When `gpr_we_o=0`, `gpr_wa_o` and `gpr_wd_o` hold their last values.
- A granted write to x0 is consumed (ready asserted) and discarded; it does not touch the scoreboard.

**Scoreboard**
- One 2-bit pending counter per register x1..x31. x0 is never busy.
- Set: `sb_set_i && sb_set_ready_o && addr != 0` increments the counter.
- Commit: the cycle `gpr_we_o=1` decrements the counter at `gpr_wa_o`.
- Set and commit to the same register in the same cycle leave its count unchanged.
- `sb_set_ready_o = 0` when the addressed counter equals 3. A set while not ready is ignored.
- Commit to a counter at 0: the counter stays 0 and `sb_err_o` latches to 1 until reset.
- `sb_busyN_o = (count[sb_raN_i] != 0)`, combinational. It still reads busy during the commit cycle, because the register file writes on that edge.

## Timing
- Grant to `gpr_we_o`: 1 cycle. Grant to scoreboard decrement: 1 cycle after the grant, at the same edge as the register-file write.
- `sb_busy` falls the cycle after `gpr_we_o` for a count of 1.
- A set becomes visible on `sb_busy` the cycle after `sb_set_i`.
- Reset values: `gpr_we_o=0`, `gpr_wa_o=0`, `gpr_wd_o=0`, all counters 0, `sb_err_o=0`, round-robin pointer 0.
- `req_ready_o` is 0 while `rst_ni=0`.
- Reset asserted mid-operation discards any staged write: `gpr_we_o=0` on the next edge.

## Configuration
- `RISCV_GPR_WB_RR_EN` defined: round-robin arbitration.
  - After a grant to i, priority starts at `(i+1) mod NREQ`.
  - The pointer advances only on a grant.
- `RISCV_GPR_WB_RR_EN` undefined: fixed priority, requester 0 highest. The pointer logic is absent.

## Test plan
- After reset: `gpr_we_o=0`, `sb_busy1_o=0` for every `sb_ra1_i`, `sb_err_o=0`. With all `req_valid_i=1`, no ready is asserted while `rst_ni=0`.
- Single write: req1 valid, addr 5, data 0xDEADBEEF at cycle N → `req_ready_o=3'b010` at N. At N+1: `gpr_we_o=1`, `gpr_wa_o=5`, `gpr_wd_o=0xDEADBEEF`. At N+2: `gpr_we_o=0`.
- Contention with all three valid for 6 cycles:
  - RR build: grants 0,1,2,0,1,2.
  - Fixed build: grants 0 every cycle.
- Scoreboard:
  - Set x7 twice → busy(x7)=1.
  - One commit → busy still 1. Second commit → busy 0 the cycle after `gpr_we_o`.
  - Fourth set while count=3 → `sb_set_ready_o=0`, count stays 3.
- Simultaneous set and commit of x9 at count 1 → count stays 1, busy stays 1.
- Edge cases:
  - Write to x0 → ready=1, `gpr_we_o=0` next cycle, no scoreboard change.
  - Commit to x3 with count 0 → `sb_err_o=1` and it stays 1 until reset.
